// File: rtl/muldiv_seq_divider_pkg.sv
// rtl/muldiv_seq_divider_pkg.sv - shared ALU op encodings and divider FSM types
//
// Op codes are the EX-stage ALU select values shared with the rest of the
// pipeline. Only the four divide ops are acted on by the divider; the others
// are listed so callers and benches can name them.

package muldiv_seq_divider_pkg;

    localparam int DIV_XLEN = 32;

    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_MUL  = 5'h0c;
    localparam logic [4:0] OP_DIV  = 5'h10;
    localparam logic [4:0] OP_DIVU = 5'h11;
    localparam logic [4:0] OP_REM  = 5'h12;
    localparam logic [4:0] OP_REMU = 5'h13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

    function automatic logic is_signed_op(input logic [4:0] op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic is_rem_op(input logic [4:0] op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// rtl/div_iter_step.sv - one combinational radix-2 restoring division step
//
// Ports:
//   rem_in   in  XLEN  partial remainder from the previous step (always < divisor)
//   dvd_msb  in  1     next dividend bit shifted into the remainder
//   divisor  in  XLEN  divisor magnitude
//   rem_out  out XLEN  partial remainder after this step
//   q_bit    out 1     quotient bit produced by this step

module div_iter_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] rem_in,
    input  logic            dvd_msb,
    input  logic [XLEN-1:0] divisor,
    output logic [XLEN-1:0] rem_out,
    output logic            q_bit
);

    // The shifted remainder needs XLEN+1 bits: with a divisor above 2^(XLEN-1)
    // the previous remainder can already have its top bit set.
    logic [XLEN:0]   partial;
    logic [XLEN-1:0] diff;

    always_comb begin
        partial = {rem_in, dvd_msb};
        q_bit   = (partial >= {1'b0, divisor});
        // When the subtraction succeeds the true difference is below the
        // divisor, so the low XLEN bits of the modular difference are exact.
        diff    = partial[XLEN-1:0] - divisor;
        rem_out = q_bit ? diff : partial[XLEN-1:0];
    end

endmodule

// File: rtl/muldiv_seq_divider.sv
// rtl/muldiv_seq_divider.sv - multi-cycle restoring divider for DIV/DIVU/REM/REMU
//
// Ports:
//   clk     in   1     clock, all state on posedge
//   reset   in   1     asynchronous active-high reset
//   start   in   1     issue strobe, sampled only while busy=0
//   select  in   5     ALU op code (OP_DIV/OP_DIVU/OP_REM/OP_REMU accepted)
//   data1   in   XLEN  dividend (rs1)
//   data2   in   XLEN  divisor (rs2)
//   flush   in   1     abort the in-flight op; no done follows
//   busy    out  1     op in flight; the pipeline holds EX while high
//   done    out  1     one-cycle pulse, result valid in this cycle
//   result  out  XLEN  quotient or remainder, held until the next done
//
// Flow: IDLE -accept-> CALC (32 restoring steps) -> FIX (sign fix, write
// result) -> IDLE with done high. Divide-by-zero and signed overflow may
// complete straight from IDLE when FAST_SPECIAL is set.

module muldiv_seq_divider
    import muldiv_seq_divider_pkg::*;
#(
    parameter int XLEN         = DIV_XLEN,
    parameter bit FAST_SPECIAL = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [4:0]      select,
    input  logic [XLEN-1:0] data1,
    input  logic [XLEN-1:0] data2,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    div_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [XLEN-1:0] dvd_q;
    logic [XLEN-1:0] dsr_q;
    logic [XLEN-1:0] rem_q;
    logic [XLEN-1:0] quot_q;
    logic            is_rem_q;
    logic            q_neg_q;
    logic            r_neg_q;

    logic            accept;
    logic            op_signed;
    logic            op_rem;
    logic            a_neg;
    logic            b_neg;
    logic [XLEN-1:0] a_mag;
    logic [XLEN-1:0] b_mag;
    logic            div_zero;
    logic            overflow;
    logic            special;
    logic [XLEN-1:0] special_result;
    logic [XLEN-1:0] fix_quot;
    logic [XLEN-1:0] fix_rem;

    logic [XLEN-1:0] step_rem;
    logic            step_q;

    always_comb begin
        op_signed = is_signed_op(select);
        op_rem    = is_rem_op(select);
        accept    = start && !flush && (state_q == ST_IDLE) && is_div_op(select);

        a_neg = op_signed && data1[XLEN-1];
        b_neg = op_signed && data2[XLEN-1];
        a_mag = a_neg ? -data1 : data1;
        b_mag = b_neg ? -data2 : data2;

        div_zero = (data2 == '0);
        overflow = op_signed && (data1 == MOST_NEG) && (data2 == '1);
        special  = div_zero || overflow;

        special_result = '0;
        if (div_zero) begin
            special_result = op_rem ? data1 : '1;
        end else begin
            special_result = op_rem ? '0 : MOST_NEG;
        end

        fix_quot = q_neg_q ? -quot_q : quot_q;
        fix_rem  = r_neg_q ? -rem_q : rem_q;
    end

    div_iter_step #(
        .XLEN(XLEN)
    ) u_step (
        .rem_in (rem_q),
        .dvd_msb(dvd_q[XLEN-1]),
        .divisor(dsr_q),
        .rem_out(step_rem),
        .q_bit  (step_q)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            dvd_q    <= '0;
            dsr_q    <= '0;
            rem_q    <= '0;
            quot_q   <= '0;
            is_rem_q <= 1'b0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            result   <= '0;
        end else begin
            done <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        is_rem_q <= op_rem;
                        // A zero divisor leaves an all-ones magnitude quotient
                        // that must stay all-ones regardless of operand signs.
                        q_neg_q  <= (a_neg ^ b_neg) && !div_zero;
                        r_neg_q  <= a_neg;
                        if (FAST_SPECIAL && special) begin
                            result <= special_result;
                            done   <= 1'b1;
                        end else begin
                            dvd_q   <= a_mag;
                            dsr_q   <= b_mag;
                            rem_q   <= '0;
                            quot_q  <= '0;
                            cnt_q   <= CNT_W'(XLEN - 1);
                            busy    <= 1'b1;
                            state_q <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    if (flush) begin
                        busy    <= 1'b0;
                        state_q <= ST_IDLE;
                    end else begin
                        rem_q  <= step_rem;
                        quot_q <= {quot_q[XLEN-2:0], step_q};
                        dvd_q  <= {dvd_q[XLEN-2:0], 1'b0};
                        cnt_q  <= cnt_q - 1'b1;
                        if (cnt_q == '0) begin
                            state_q <= ST_FIX;
                        end
                    end
                end
                ST_FIX: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                    if (!flush) begin
                        result <= is_rem_q ? fix_rem : fix_quot;
                        done   <= 1'b1;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq_divider.sv
// tb/tb_muldiv_seq_divider.sv - scoreboard bench for muldiv_seq_divider (fast and slow special paths)

module tb_muldiv_seq_divider;
    import muldiv_seq_divider_pkg::*;

    typedef struct {
        logic [31:0] res;
        int          cyc;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        f_start, s_start;
    logic [4:0]  f_select, s_select;
    logic [31:0] f_data1, f_data2, s_data1, s_data2;
    logic        f_flush, s_flush;
    logic        f_busy, f_done, s_busy, s_done;
    logic [31:0] f_result, s_result;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t q0[$];
    exp_t q1[$];
    exp_t e0, e1;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    muldiv_seq_divider #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut_fast (
        .clk(clk), .reset(reset), .start(f_start), .select(f_select),
        .data1(f_data1), .data2(f_data2), .flush(f_flush),
        .busy(f_busy), .done(f_done), .result(f_result)
    );

    muldiv_seq_divider #(.XLEN(32), .FAST_SPECIAL(1'b0)) dut_slow (
        .clk(clk), .reset(reset), .start(s_start), .select(s_select),
        .data1(s_data1), .data2(s_data2), .flush(s_flush),
        .busy(s_busy), .done(s_done), .result(s_result)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: every done pops one expectation (value and arrival cycle).
    always @(negedge clk) begin
        if (f_done) begin
            if (q0.size() == 0) begin
                chk("unexpected_done_fast", 32'd1, 32'd0);
            end else begin
                e0 = q0.pop_front();
                chk({e0.name, "_result"}, f_result, e0.res);
                chk({e0.name, "_cycle"}, 32'(cyc), 32'(e0.cyc));
                chk({e0.name, "_busy_with_done"}, {31'd0, f_busy}, 32'd0);
            end
        end
        if (s_done) begin
            if (q1.size() == 0) begin
                chk("unexpected_done_slow", 32'd1, 32'd0);
            end else begin
                e1 = q1.pop_front();
                chk({e1.name, "_result"}, s_result, e1.res);
                chk({e1.name, "_cycle"}, 32'(cyc), 32'(e1.cyc));
                chk({e1.name, "_busy_with_done"}, {31'd0, s_busy}, 32'd0);
            end
        end
    end

    // Called at a negedge; drives one start cycle and returns at the next negedge.
    task automatic issue(input int k, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic push, input logic [31:0] exp,
                         input int lat, input string name);
        exp_t e;
        if (k == 0) begin
            f_start = 1'b1; f_select = op; f_data1 = a; f_data2 = b;
        end else begin
            s_start = 1'b1; s_select = op; s_data1 = a; s_data2 = b;
        end
        if (push) begin
            e.res  = exp;
            e.cyc  = cyc + 1 + lat;
            e.name = name;
            if (k == 0) q0.push_back(e);
            else        q1.push_back(e);
        end
        @(negedge clk);
        f_start = 1'b0;
        s_start = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", 32'(q0.size() + q1.size()), 32'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic wait_done_fast();
        int n = 0;
        while (!f_done && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done_timeout", {31'd0, f_done}, 32'd1);
    endtask

    initial begin
        int bad;
        reset = 1'b1;
        f_start = 0; f_select = OP_ADD; f_data1 = 0; f_data2 = 0; f_flush = 0;
        s_start = 0; s_select = OP_ADD; s_data1 = 0; s_data2 = 0; s_flush = 0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("reset_busy", {31'd0, f_busy}, 32'd0);
        chk("reset_done", {31'd0, f_done}, 32'd0);
        chk("reset_result", f_result, 32'd0);
        chk("reset_result_slow", s_result, 32'd0);

        // 1: DIV 100/7 with busy window over edges 1..33
        issue(0, OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 33, "div_100_7");
        bad = 0;
        for (int i = 0; i <= 33; i++) begin
            if (f_busy !== (i <= 32)) bad++;
            @(negedge clk);
        end
        chk("busy_window", 32'(bad), 32'd0);
        drain();

        // 2: signed remainder, back-to-back DIVU in the done cycle, REMU
        issue(0, OP_REM, 32'hFFFFFF9C, 32'd7, 1'b1, 32'hFFFFFFFE, 33, "rem_m100_7");
        wait_done_fast();
        issue(0, OP_DIVU, 32'hFFFFFFFF, 32'd2, 1'b1, 32'h7FFFFFFF, 33, "divu_max_2");
        drain();
        issue(0, OP_REMU, 32'hFFFFFFFF, 32'd16, 1'b1, 32'd15, 33, "remu_max_16");
        drain();
        issue(0, OP_DIVU, 32'hFFFFFFFF, 32'h80000001, 1'b1, 32'd1, 33, "divu_big");
        drain();
        issue(0, OP_REMU, 32'hFFFFFFFF, 32'h80000001, 1'b1, 32'h7FFFFFFE, 33, "remu_big");
        drain();
        issue(0, OP_DIV, 32'hFFFFFFF9, 32'd2, 1'b1, 32'hFFFFFFFD, 33, "div_m7_2");
        drain();
        issue(0, OP_REM, 32'd7, 32'hFFFFFFFE, 1'b1, 32'd1, 33, "rem_7_m2");
        drain();

        // 3/4: special cases, fast path completes one cycle after accept
        issue(0, OP_DIV, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 0, "fast_div_5_0");
        issue(0, OP_REM, 32'd5, 32'd0, 1'b1, 32'd5, 0, "fast_rem_5_0");
        issue(0, OP_DIV, 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 0, "fast_div_m5_0");
        issue(0, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 0, "fast_div_ovf");
        issue(0, OP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 0, "fast_rem_ovf");
        drain();

        // Same special cases through the iterative path
        issue(1, OP_DIV, 32'd5, 32'd0, 1'b1, 32'hFFFFFFFF, 33, "slow_div_5_0");
        drain();
        issue(1, OP_REM, 32'd5, 32'd0, 1'b1, 32'd5, 33, "slow_rem_5_0");
        drain();
        issue(1, OP_DIV, 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFF, 33, "slow_div_m5_0");
        drain();
        issue(1, OP_REM, 32'hFFFFFFFB, 32'd0, 1'b1, 32'hFFFFFFFB, 33, "slow_rem_m5_0");
        drain();
        issue(1, OP_DIVU, 32'd9, 32'd0, 1'b1, 32'hFFFFFFFF, 33, "slow_divu_9_0");
        drain();
        issue(1, OP_DIV, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'h80000000, 33, "slow_div_ovf");
        drain();
        issue(1, OP_REM, 32'h80000000, 32'hFFFFFFFF, 1'b1, 32'd0, 33, "slow_rem_ovf");
        drain();

        // 5: non-divide op is ignored; flush blocks accept in idle
        issue(0, OP_ADD, 32'd3, 32'd4, 1'b0, 32'd0, 0, "");
        chk("add_no_busy", {31'd0, f_busy}, 32'd0);
        f_flush = 1'b1;
        issue(0, OP_DIV, 32'd8, 32'd2, 1'b0, 32'd0, 0, "");
        f_flush = 1'b0;
        chk("flush_blocks_accept", {31'd0, f_busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("ignored_ops_keep_result", f_result, 32'd0);

        // start while busy is ignored, current op still completes
        issue(0, OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 33, "div_busy_start");
        repeat (5) @(negedge clk);
        issue(0, OP_DIV, 32'd1, 32'd1, 1'b0, 32'd0, 0, "");
        drain();
        repeat (40) @(negedge clk);

        // 6: flush mid-CALC, no done, result unchanged
        issue(0, OP_DIV, 32'd1000, 32'd10, 1'b0, 32'd0, 0, "");
        repeat (10) @(negedge clk);
        f_flush = 1'b1;
        @(negedge clk);
        f_flush = 1'b0;
        chk("flush_busy", {31'd0, f_busy}, 32'd0);
        repeat (40) @(negedge clk);
        chk("flush_result_kept", f_result, 32'd14);

        // asynchronous reset mid-CALC
        issue(0, OP_DIVU, 32'd12345, 32'd3, 1'b0, 32'd0, 0, "");
        repeat (6) @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_busy", {31'd0, f_busy}, 32'd0);
        chk("async_reset_done", {31'd0, f_done}, 32'd0);
        chk("async_reset_result", f_result, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        issue(0, OP_DIV, 32'd100, 32'd7, 1'b1, 32'd14, 33, "div_after_reset");
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
